// File: rtl/csr_pkg.sv
// Shared CSR map, modify codes and UART state encoding for the pipeline's CSR peripherals.
package csr_pkg;

  localparam logic [11:0] CSR_UART  = 12'hBC0;
  localparam logic [11:0] CSR_LEDS  = 12'hBC1;
  localparam logic [11:0] CSR_SWI   = 12'hBC1;
  localparam logic [11:0] CSR_TIMER = 12'hBC2;
  localparam logic [11:0] CSR_KHZ   = 12'hFC0;
  localparam logic [11:0] CSR_SIM   = 12'h3FF;

  localparam logic [2:0] MOD_NONE  = 3'd0;
  localparam logic [2:0] MOD_WRITE = 3'd1;
  localparam logic [2:0] MOD_SET   = 3'd2;
  localparam logic [2:0] MOD_CLEAR = 3'd3;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP,
    UART_WAIT_HIGH
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry a wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int LOG2  = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int DEPTH = 2 ** LOG2;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LOG2:0]    wptr_q, wptr_d;
  logic [LOG2:0]    rptr_q, rptr_d;
  logic             push_ok, pop_ok;

  // A pop frees the slot a same-cycle push needs, so full only blocks an unpaired push.
  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[LOG2] != rptr_q[LOG2]) &&
              (wptr_q[LOG2-1:0] == rptr_q[LOG2-1:0]);
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    wptr_d  = wptr_q + {{LOG2{1'b0}}, push_ok};
    rptr_d  = rptr_q + {{LOG2{1'b0}}, pop_ok};
    rdata   = mem_q[rptr_q[LOG2-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[LOG2-1:0]] <= wdata;
  end

endmodule

// File: rtl/csr_uart_fifo.sv
// CSR-mapped 8N1 UART with TX/RX FIFOs; one data/status register at BASE_ADDR.
module csr_uart_fifo
  import csr_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR  = CSR_UART,
  parameter int          CLOCK_RATE = 1000000,
  parameter int          BAUD_RATE  = 115200,
  parameter int          FIFO_LOG2  = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx,
  output logic        tx
);

  localparam int DIVIDER = CLOCK_RATE / BAUD_RATE;
  localparam int CNT_W   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIVIDER - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVIDER / 2 - 1);

  logic        hit_q, hit_d;
  logic [31:0] rdata_q, rdata_d;
  logic        overrun_q, overrun_d;
  logic        rd_hit;
  logic        unused_wdata;

  logic       tx_push, tx_pop, tx_empty, tx_full;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] rx_head;

  uart_state_e      tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_tick;

  uart_state_e      rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic             rx_tick, rx_fall;

  assign unused_wdata = ^wdata[31:8];
  assign valid        = hit_q;
  assign rdata        = rdata_q;
  assign tx_tick      = (tx_cnt_q == DIV_LAST);
  assign rx_tick      = (rx_cnt_q == DIV_LAST);
  assign rx_fall      = rx_prev_q && !rx_s2_q;

  sync_fifo #(.WIDTH(8), .LOG2(FIFO_LOG2)) u_tx_fifo (
    .clk(clk), .rstn(rstn), .push(tx_push), .wdata(wdata[7:0]), .pop(tx_pop),
    .rdata(tx_head), .empty(tx_empty), .full(tx_full)
  );

  sync_fifo #(.WIDTH(8), .LOG2(FIFO_LOG2)) u_rx_fifo (
    .clk(clk), .rstn(rstn), .push(rx_push), .wdata(rx_shift_q), .pop(rx_pop),
    .rdata(rx_head), .empty(rx_empty), .full(rx_full)
  );

  // Read side acts at the address cycle; write side one cycle later on the registered hit.
  always_comb begin
    rd_hit  = read && (addr == BASE_ADDR);
    hit_d   = (addr == BASE_ADDR);
    rx_pop  = rd_hit && !rx_empty;
    tx_push = hit_q && (modify == MOD_WRITE);
    rdata_d = '0;
    if (rd_hit) rdata_d = {21'b0, overrun_q, tx_full, rx_empty, rx_empty ? 8'h00 : rx_head};
    overrun_d = overrun_q;
    if (rd_hit) overrun_d = 1'b0;
    if (rx_push && rx_full && !rx_pop) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hit_q     <= 1'b0;
      rdata_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      hit_q     <= hit_d;
      rdata_q   <= rdata_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_state_q <= UART_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      rx_state_q <= UART_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_shift_q <= tx_shift_d;
    rx_shift_q <= rx_shift_d;
  end

  // TX: every non-idle state holds for DIVIDER cycles.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    if (tx_state_q != UART_IDLE) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
    unique case (tx_state_q)
      UART_IDLE: begin
        if (!tx_empty) begin
          tx_state_d = UART_START;
          tx_shift_d = tx_head;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end
      end
      UART_START: if (tx_tick) tx_state_d = UART_DATA;
      UART_DATA: begin
        if (tx_tick) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 1'b1;
          if (tx_bit_q == 3'd7) tx_state_d = UART_STOP;
        end
      end
      UART_STOP: if (tx_tick) tx_state_d = UART_IDLE;
      default:   tx_state_d = UART_IDLE;
    endcase
  end

  always_comb begin
    tx_pop = (tx_state_q == UART_IDLE) && !tx_empty;
    unique case (tx_state_q)
      UART_START: tx = 1'b0;
      UART_DATA:  tx = tx_shift_q[0];
      default:    tx = 1'b1;
    endcase
  end

  // RX: the cycle the edge is seen counts as the first start-bit cycle, so samples land mid-bit.
  always_comb begin
    rx_s1_d    = rx;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    unique case (rx_state_q)
      UART_IDLE: begin
        if (rx_fall) begin
          rx_state_d = UART_START;
          rx_cnt_d   = '0;
        end
      end
      UART_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? UART_IDLE : UART_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      UART_DATA: begin
        if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = UART_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      UART_STOP: begin
        if (rx_tick) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_s2_q ? UART_IDLE : UART_WAIT_HIGH;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      UART_WAIT_HIGH: if (rx_s2_q) rx_state_d = UART_IDLE;
      default:        rx_state_d = UART_IDLE;
    endcase
  end

  always_comb begin
    rx_push = (rx_state_q == UART_STOP) && rx_tick && rx_s2_q;
  end

endmodule

// File: tb/tb_csr_uart_fifo.sv
// Bench for csr_uart_fifo at DIVIDER=10: vector table, directed corner sequences, randomized RX vs queue model.
module tb_csr_uart_fifo;

  logic        clk = 1'b0;
  logic        rstn, read, rx;
  logic [2:0]  modify;
  logic [31:0] wdata;
  logic [11:0] addr;
  logic [31:0] rdata;
  logic        valid, tx;

  csr_uart_fifo #(
    .BASE_ADDR(12'hBC0), .CLOCK_RATE(1000000), .BAUD_RATE(100000), .FIFO_LOG2(3)
  ) dut (
    .clk(clk), .rstn(rstn), .read(read), .modify(modify), .wdata(wdata),
    .addr(addr), .rdata(rdata), .valid(valid), .rx(rx), .tx(tx)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // TX line monitor: captures 100-cycle frames, decodes mid-bit, then checks every cycle of the shape.
  logic [7:0]  tx_frames [$];
  int          shape_bad = 0;
  logic [99:0] mon_s;
  logic [7:0]  mon_b;
  logic        mon_ab, mon_e, mon_bad;

  always begin
    @(negedge clk);
    if (rstn === 1'b1 && tx === 1'b0) begin
      mon_ab = 1'b0;
      mon_s  = '0;
      for (int i = 1; i < 100; i++) begin
        @(negedge clk);
        if (rstn !== 1'b1) mon_ab = 1'b1;
        mon_s[i] = tx;
      end
      if (!mon_ab) begin
        for (int j = 0; j < 8; j++) mon_b[j] = mon_s[15 + 10 * j];
        mon_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
          mon_e = (i < 10) ? 1'b0 : (i >= 90) ? 1'b1 : mon_b[(i - 10) / 10];
          if (mon_s[i] !== mon_e) mon_bad = 1'b1;
        end
        if (mon_bad) shape_bad++;
        tx_frames.push_back(mon_b);
      end
    end
  end

  // Reference RX model: 8-deep queue, sticky overrun cleared by any read.
  logic [7:0] rxq [$];
  logic       ovr = 1'b0;

  function automatic void model_rx(input logic [7:0] b);
    if (rxq.size() < 8) rxq.push_back(b);
    else ovr = 1'b1;
  endfunction

  function automatic logic [31:0] model_read();
    logic [31:0] v;
    v = {21'b0, ovr, 1'b0, (rxq.size() == 0), 8'h00};
    if (rxq.size() != 0) v[7:0] = rxq.pop_front();
    ovr = 1'b0;
    return v;
  endfunction

  task automatic csr_op(input logic [11:0] a, input logic rd, input logic [2:0] m,
                        input logic [31:0] wd, output logic v, output logic [31:0] r);
    @(negedge clk); addr = a; read = rd; modify = 3'd0; wdata = '0;
    @(negedge clk); addr = 12'h000; read = 1'b0; modify = m; wdata = wd;
    v = valid;
    r = rdata;
    @(negedge clk); modify = 3'd0; wdata = '0;
  endtask

  task automatic csr_chk(input string nm, input logic [11:0] a, input logic rd, input logic [2:0] m,
                         input logic [31:0] wd, input logic ev, input logic [31:0] er);
    logic        v;
    logic [31:0] r;
    csr_op(a, rd, m, wd, v, r);
    check({nm, "_valid"}, {31'b0, v}, {31'b0, ev});
    check({nm, "_rdata"}, r, er);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (10) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  function automatic logic [31:0] pop_frame();
    if (tx_frames.size() == 0) return 32'hDEAD;
    return {24'b0, tx_frames.pop_front()};
  endfunction

  typedef struct {
    logic [11:0] a;
    logic        rd;
    logic [2:0]  m;
    logic [31:0] wd;
    logic        ev;
    logic [31:0] er;
  } vec_t;

  vec_t tbl [9];

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [31:0] e;
    int          k, n0;

    tbl[0] = '{12'hBC0, 1'b1, 3'd0, 32'h00, 1'b1, 32'h100};
    tbl[1] = '{12'hBC1, 1'b1, 3'd0, 32'h00, 1'b0, 32'h000};
    tbl[2] = '{12'hBC2, 1'b1, 3'd0, 32'h00, 1'b0, 32'h000};
    tbl[3] = '{12'hFC0, 1'b1, 3'd0, 32'h00, 1'b0, 32'h000};
    tbl[4] = '{12'h3FF, 1'b1, 3'd0, 32'h00, 1'b0, 32'h000};
    tbl[5] = '{12'hBC0, 1'b0, 3'd0, 32'h00, 1'b1, 32'h000};
    tbl[6] = '{12'hBC0, 1'b0, 3'd2, 32'h41, 1'b1, 32'h000};
    tbl[7] = '{12'hBC0, 1'b0, 3'd3, 32'hFF, 1'b1, 32'h000};
    tbl[8] = '{12'hBC1, 1'b0, 3'd1, 32'h42, 1'b0, 32'h000};

    rstn = 1'b0; read = 1'b0; modify = 3'd0; wdata = '0; addr = '0; rx = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    rstn = 1'b1;

    for (int i = 0; i < 9; i++)
      csr_chk($sformatf("tbl%0d", i), tbl[i].a, tbl[i].rd, tbl[i].m, tbl[i].wd, tbl[i].ev, tbl[i].er);
    repeat (250) @(negedge clk);
    check("no_frame_nonwrite", tx_frames.size(), 0);

    // Single frame, exact waveform
    csr_chk("wr55", 12'hBC0, 1'b0, 3'd1, 32'h55, 1'b1, 32'h0);
    repeat (130) @(negedge clk);
    check("tx55_count", tx_frames.size(), 1);
    check("tx55_byte", pop_frame(), 32'h55);
    check("tx55_shape", shape_bad, 0);

    // Back-to-back fill: one in the shifter, eight queued, tenth dropped
    @(negedge clk); addr = 12'hBC0; read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      modify = 3'd1;
      wdata  = 32'h30 + i;
      addr   = (i < 9) ? 12'hBC0 : 12'h000;
    end
    @(negedge clk); modify = 3'd0; wdata = '0; addr = 12'hBC0; read = 1'b1;
    @(negedge clk); addr = 12'h000; read = 1'b0;
    check("fill_valid", {31'b0, valid}, 32'd1);
    check("fill_txfull", rdata, 32'h300);
    repeat (9 * 101 + 250) @(negedge clk);
    check("fill_count", tx_frames.size(), 9);
    for (int i = 0; i < 9; i++) check($sformatf("fill_byte%0d", i), pop_frame(), 32'h30 + i);
    check("fill_shape", shape_bad, 0);

    // RX basic, glitch, framing error
    send_rx(8'hA3, 1'b1);
    repeat (5) @(negedge clk);
    csr_chk("rxA3", 12'hBC0, 1'b1, 3'd0, 32'h0, 1'b1, 32'h0A3);
    csr_chk("rx_empty", 12'hBC0, 1'b1, 3'd0, 32'h0, 1'b1, 32'h100);
    rx = 1'b0; repeat (3) @(negedge clk); rx = 1'b1;
    repeat (40) @(negedge clk);
    csr_chk("rx_glitch", 12'hBC0, 1'b1, 3'd0, 32'h0, 1'b1, 32'h100);
    send_rx(8'h5A, 1'b0);
    repeat (20) @(negedge clk);
    csr_chk("rx_framing", 12'hBC0, 1'b1, 3'd0, 32'h0, 1'b1, 32'h100);
    send_rx(8'h3C, 1'b1);
    repeat (5) @(negedge clk);
    csr_chk("rx_after_ferr", 12'hBC0, 1'b1, 3'd0, 32'h0, 1'b1, 32'h03C);

    // Overrun: nine frames into an 8-deep FIFO
    for (int i = 0; i < 9; i++) send_rx(8'hC0 + 8'(i), 1'b1);
    repeat (5) @(negedge clk);
    csr_chk("ovr_first", 12'hBC0, 1'b1, 3'd0, 32'h0, 1'b1, 32'h4C0);
    for (int i = 1; i < 8; i++)
      csr_chk($sformatf("ovr_rd%0d", i), 12'hBC0, 1'b1, 3'd0, 32'h0, 1'b1, 32'hC0 + i);
    csr_chk("ovr_drained", 12'hBC0, 1'b1, 3'd0, 32'h0, 1'b1, 32'h100);

    // Randomized RX traffic and reads against the queue model
    rxq.delete();
    ovr = 1'b0;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        b = 8'($urandom_range(0, 255));
        send_rx(b, 1'b1);
        model_rx(b);
        repeat (3) @(negedge clk);
      end else begin
        e = model_read();
        csr_chk($sformatf("rnd%0d", it), 12'hBC0, 1'b1, 3'd0, 32'h0, 1'b1, e);
      end
    end
    while (rxq.size() != 0) begin
      e = model_read();
      csr_chk("rnd_drain", 12'hBC0, 1'b1, 3'd0, 32'h0, 1'b1, e);
    end
    e = model_read();
    csr_chk("rnd_final", 12'hBC0, 1'b1, 3'd0, 32'h0, 1'b1, e);

    // Reset in the middle of a TX frame with another byte queued
    csr_chk("rst_wr1", 12'hBC0, 1'b0, 3'd1, 32'h81, 1'b1, 32'h0);
    csr_chk("rst_wr2", 12'hBC0, 1'b0, 3'd1, 32'h7E, 1'b1, 32'h0);
    k = 0;
    while (tx !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("rst_frame_started", {31'b0, (k < 300)}, 32'd1);
    repeat (30) @(negedge clk);
    n0 = tx_frames.size();
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_tx", {31'b0, tx}, 32'd1);
    check("midrst_valid", {31'b0, valid}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    csr_chk("midrst_read", 12'hBC0, 1'b1, 3'd0, 32'h0, 1'b1, 32'h100);
    repeat (300) @(negedge clk);
    check("midrst_no_frame", tx_frames.size(), n0);
    check("midrst_tx_idle", {31'b0, tx}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
